register_file: RTL

Thirty-two-entry, 64-bit general-purpose register file for the ARM pipeline: the responder to the register-address selection done in decode. It takes two read addresses, the second being the Reg2Loc-selected field (Rm = PR1[20:16] or Rt = PR1[4:0]), and returns operands combinationally. It accepts one write per cycle from the write-back stage. X31 is hard-wired as XZR. A same-cycle write is bypassed to the read ports so decode never sees stale data.

---
 rtl/register_file.sv | 81 ++++++++
 1 files changed

// File: rtl/register_file.sv
`default_nettype none
// ==== register_file : 32 x 64-bit ARM GPR file, X31 reads as XZR, same-cycle write bypass | rev 1.0 ====
module register_file #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32,
  parameter int ZERO_REG = 31,
  parameter int BYPASS   = 1
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic [ADDR_W-1:0] ReadReg1,
  input  logic [ADDR_W-1:0] ReadReg2,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] WriteReg,
  input  logic [DATA_W-1:0] WriteData,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic [15:0]       WriteCount
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);
  localparam bit                BYPASS_EN = (BYPASS != 0);

  logic [DATA_W-1:0] mem [NUM_REGS];
  logic              wr_in_range;
  logic              rd1_in_range;
  logic              rd2_in_range;
  logic              wr_hit;
  logic              bypass_ok;

  // Only a partially populated address space needs the out-of-range guard.
  generate
    if (NUM_REGS < (1 << ADDR_W)) begin : g_range_check
      assign wr_in_range  = (32'(WriteReg) < NUM_REGS);
      assign rd1_in_range = (32'(ReadReg1) < NUM_REGS);
      assign rd2_in_range = (32'(ReadReg2) < NUM_REGS);
    end else begin : g_full_range
      assign wr_in_range  = 1'b1;
      assign rd1_in_range = 1'b1;
      assign rd2_in_range = 1'b1;
    end
  endgenerate

  assign wr_hit    = RegWrite && (WriteReg != ZERO_ADDR) && wr_in_range;
  assign bypass_ok = BYPASS_EN && RST_n && wr_hit;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem[i] <= '0;
      end
      WriteCount <= '0;
    end else if (wr_hit) begin
      mem[WriteReg] <= WriteData;
      if (WriteCount != 16'hFFFF) begin
        WriteCount <= WriteCount + 16'd1;
      end
    end
  end

  always_comb begin
    ReadData1 = mem[ReadReg1];
    if (!RST_n || !rd1_in_range || (ReadReg1 == ZERO_ADDR)) begin
      ReadData1 = '0;
    end else if (bypass_ok && (WriteReg == ReadReg1)) begin
      ReadData1 = WriteData;
    end
  end

  always_comb begin
    ReadData2 = mem[ReadReg2];
    if (!RST_n || !rd2_in_range || (ReadReg2 == ZERO_ADDR)) begin
      ReadData2 = '0;
    end else if (bypass_ok && (WriteReg == ReadReg2)) begin
      ReadData2 = WriteData;
    end
  end

endmodule
`default_nettype wire
